gray_counter: RTL

- Parameterised up/down counter that presents its count as Gray code, in registered form.
- Sits directly upstream of the Gray-to-binary converter: its gray_out bus drives that converter's 4-bit Gray input, and the converter recovers the binary count.
- Only one bit of gray_out changes per count step, so the bus is safe to pass across clock domains or to sample asynchronously downstream.

---
 rtl/gray_counter_if.sv | 13 +
 rtl/gray_counter.sv | 33 +++
 2 files changed

// File: rtl/gray_counter_if.sv
// gray_counter_if: control and Gray-coded count bus for gray_counter
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;
  modport master (output en, up_dn, load, load_val, input gray_out, wrap);
  modport slave  (input en, up_dn, load, load_val, output gray_out, wrap);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with registered Gray-coded output and wrap pulse
module gray_counter #(
  parameter int               WIDTH    = 4,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input logic          clk,
  input logic          rst,
  gray_counter_if.slave bus
);
  logic [WIDTH-1:0] cnt, next_cnt, stepped;
  logic             edge_hit, next_wrap, move;
  // next count: load beats a step, and a step at the range end either wraps or holds
  always_comb begin
    edge_hit  = bus.up_dn ? &cnt : ~|cnt;
    stepped   = bus.up_dn ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
    move      = bus.en && !(SATURATE && edge_hit);
    next_cnt  = bus.load ? bus.load_val : move ? stepped : cnt;
    next_wrap = !bus.load && bus.en && edge_hit && !SATURATE;
  end
  // count, Gray output and wrap all update together from next_cnt, so gray_out never lags cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= RST_VAL;
      bus.gray_out <= RST_VAL ^ (RST_VAL >> 1);
      bus.wrap     <= 1'b0;
    end else begin
      cnt          <= next_cnt;
      bus.gray_out <= next_cnt ^ (next_cnt >> 1);
      bus.wrap     <= next_wrap;
    end
  end
endmodule
